alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 19 +
 rtl/alu_arbiter_rr_arb2.sv | 16 +
 rtl/alu_arbiter.sv | 99 +++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding,
// response flag bit positions and a small one-hot helper.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int FLAG_ZERO = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 0;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: prio breaks ties, a lone requester always wins.
module alu_rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = onehot2(prio);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, one
// operation in flight, results returned on the owner's response port.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_instr0,
    input  logic [31:0]      req_instr1,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [31:0]      alu_instr,
    output logic [31:0]      alu_rega,
    output logic [31:0]      alu_regb,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t     state;
    logic       prio;
    logic       owner;
    logic [1:0] grant;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    alu_rr_arb2 u_arb (
        .valid (req_valid),
        .prio  (prio),
        .grant (grant)
    );

    // Gated by rst so no grant is offered while reset is still asserted.
    assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_flags  <= '0;
            alu_instr  <= '0;
            alu_rega   <= '0;
            alu_regb   <= '0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        owner     <= grant[1];
                        alu_instr <= grant[1] ? req_instr1 : req_instr0;
                        alu_rega  <= grant[1] ? req_a1     : req_a0;
                        alu_regb  <= grant[1] ? req_b1     : req_b0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_result           <= alu_result;
                    rsp_flags[FLAG_ZERO] <= alu_zero;
                    rsp_flags[FLAG_NEG]  <= alu_negative;
                    rsp_flags[FLAG_OVF]  <= alu_overflow;
                    rsp_valid            <= onehot2(owner);
                    state                <= RESP;
                end
                RESP: begin
                    // rsp_valid carries only the owner bit, so the other ready is ignored.
                    if (|(rsp_valid & rsp_ready)) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        prio      <= ~owner;
                        op_count  <= sat_inc(op_count);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural MIPS-style ALU
// attached to the alu_* ports; counter width reduced to exercise saturation.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_instr0, req_instr1, req_a0, req_a1, req_b0, req_b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic [31:0] alu_instr, alu_rega, alu_regb;
    logic [31:0] alu_result;
    logic        alu_zero, alu_negative, alu_overflow;
    logic        busy;
    logic [1:0]  op_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_instr0   (req_instr0),
        .req_instr1   (req_instr1),
        .req_a0       (req_a0),
        .req_a1       (req_a1),
        .req_b0       (req_b0),
        .req_b1       (req_b1),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .alu_instr    (alu_instr),
        .alu_rega     (alu_rega),
        .alu_regb     (alu_regb),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .busy         (busy),
        .op_count     (op_count)
    );

    // External ALU: negative reports the sign of the true arithmetic result.
    logic [31:0] diff;
    logic        diff_ovf;
    always_comb begin
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        alu_negative = 1'b0;
        diff         = alu_rega - alu_regb;
        diff_ovf     = (alu_rega[31] != alu_regb[31]) && (diff[31] != alu_rega[31]);
        case (alu_instr[5:0])
            6'h20: begin
                alu_result   = alu_rega + alu_regb;
                alu_overflow = (alu_rega[31] == alu_regb[31]) && (alu_result[31] != alu_rega[31]);
                alu_negative = alu_result[31] ^ alu_overflow;
            end
            6'h21: begin
                alu_result   = alu_rega + alu_regb;
                alu_negative = alu_result[31];
            end
            6'h22: begin
                alu_result   = diff;
                alu_overflow = diff_ovf;
                alu_negative = diff[31] ^ diff_ovf;
            end
            6'h23: begin
                alu_result   = diff;
                alu_negative = diff[31];
            end
            6'h2a: begin
                alu_result   = {31'd0, diff[31] ^ diff_ovf};
                alu_negative = diff[31] ^ diff_ovf;
            end
            6'h24: begin
                alu_result   = alu_rega & alu_regb;
                alu_negative = alu_result[31];
            end
            6'h25: begin
                alu_result   = alu_rega | alu_regb;
                alu_negative = alu_result[31];
            end
            default: begin
                alu_result   = alu_rega ^ alu_regb;
                alu_negative = alu_result[31];
            end
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] funct);
        return {6'd0, 5'd0, 5'd1, 5'd2, 5'd0, funct};
    endfunction

    task automatic set_req(input int idx, input logic [31:0] instr, input logic [31:0] a,
                           input logic [31:0] b);
        if (idx == 0) begin
            req_instr0 = instr; req_a0 = a; req_b0 = b;
        end else begin
            req_instr1 = instr; req_a1 = a; req_b1 = b;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single transaction with rsp_ready held high: grant, ISSUE, RESP, back to IDLE.
    task automatic run_op(input int idx, input logic [31:0] instr, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [2:0] exp_flags, input logic [1:0] exp_cnt);
        logic [1:0] bit_i;
        bit_i = (idx == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        set_req(idx, instr, a, b);
        req_valid = bit_i;
        #1 check("op_req_ready", req_ready, bit_i);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("op_issue_busy", busy, 1'b1);
        check("op_issue_rega", alu_rega, a);
        check("op_issue_instr", alu_instr, instr);
        check("op_issue_rsp_valid", rsp_valid, 2'b00);
        @(negedge clk);
        #1;
        check("op_rsp_valid", rsp_valid, bit_i);
        check("op_rsp_result", rsp_result, exp_res);
        check("op_rsp_flags", rsp_flags, exp_flags);
        @(negedge clk);
        #1;
        check("op_done_rsp_valid", rsp_valid, 2'b00);
        check("op_done_busy", busy, 1'b0);
        check("op_done_count", op_count, exp_cnt);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b11;
        rsp_ready  = 2'b11;
        req_instr0 = '0; req_instr1 = '0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;

        // Reset state, with both requesters already valid.
        @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_flags", rsp_flags, 3'b000);
        check("rst_alu_instr", alu_instr, 32'd0);
        check("rst_alu_rega", alu_rega, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_op_count", op_count, 2'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        // Single op and flag corners.
        run_op(0, rtype(6'h20), 32'd5, 32'd7, 32'd12, 3'b000, 2'd1);
        run_op(1, rtype(6'h20), 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 3'b001, 2'd2);
        run_op(0, rtype(6'h23), 32'd9, 32'd9, 32'd0, 3'b100, 2'd3);
        run_op(1, rtype(6'h2a), 32'hFFFF_FFFB, 32'd3, 32'd1, 3'b010, 2'd3);
        run_op(0, rtype(6'h3f), 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 3'b010, 2'd3);

        // Backpressure on the owner, ready only on the non-owner bit.
        @(negedge clk);
        rsp_ready = 2'b10;
        set_req(0, rtype(6'h21), 32'd3, 32'd4);
        req_valid = 2'b01;
        #1 check("bp_req_ready", req_ready, 2'b01);
        @(negedge clk);
        set_req(1, rtype(6'h20), 32'd10, 32'd20);
        req_valid = 2'b10;
        #1 check("bp_issue_req_ready", req_ready, 2'b00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_rsp_valid", rsp_valid, 2'b01);
            check("bp_hold_result", rsp_result, 32'd7);
            check("bp_hold_flags", rsp_flags, 3'b000);
            check("bp_hold_req_ready", req_ready, 2'b00);
            check("bp_hold_alu_rega", alu_rega, 32'd3);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        #1;
        check("bp_release_rsp_valid", rsp_valid, 2'b00);
        check("bp_release_req_ready", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        check("bp_next_rsp_valid", rsp_valid, 2'b10);
        check("bp_next_result", rsp_result, 32'd30);

        // Contention: both valid right after reset, grants alternate every 3 cycles.
        req_valid = 2'b00;
        set_req(0, rtype(6'h20), 32'd1, 32'd1);
        set_req(1, rtype(6'h20), 32'd2, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            logic [1:0] who;
            who = (((c / 3) % 2) == 0) ? 2'b01 : 2'b10;
            #1;
            check("cont_req_ready", req_ready, (c % 3 == 0) ? who : 2'b00);
            check("cont_rsp_valid", rsp_valid, (c % 3 == 2) ? who : 2'b00);
            if (c % 3 == 2)
                check("cont_result", rsp_result, (who == 2'b01) ? 32'd2 : 32'd4);
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Reset while in ISSUE aborts silently.
        do_reset();
        @(negedge clk);
        set_req(0, rtype(6'h20), 32'd5, 32'd7);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        #1 check("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_alu_instr", alu_instr, 32'd0);
        check("abort_alu_rega", alu_rega, 32'd0);
        check("abort_rsp_valid", rsp_valid, 2'b00);
        check("abort_rsp_result", rsp_result, 32'd0);
        check("abort_op_count", op_count, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_rsp", rsp_valid, 2'b00);
            check("abort_count_hold", op_count, 2'd0);
        end

        // Saturating counter over five completions.
        run_op(0, rtype(6'h24), 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 3'b000, 2'd1);
        run_op(1, rtype(6'h25), 32'h8000_0000, 32'd1, 32'h8000_0001, 3'b010, 2'd2);
        run_op(0, rtype(6'h22), 32'd3, 32'd5, 32'hFFFF_FFFE, 3'b010, 2'd3);
        run_op(1, rtype(6'h21), 32'hFFFF_FFFF, 32'd1, 32'd0, 3'b100, 2'd3);
        run_op(0, rtype(6'h22), 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b011, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
